dlx_fetch_unit: RTL and testbench

Instruction-fetch stage of the single-issue DLX datapath. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. It holds the fetched word steady on `inst` for the control decoder and datapath. When the datapath signals retirement, it computes the next PC from the decoder's branch/jump outputs (`branch_z`, `branch_nz`, `jmp`, `jmp_r`) and the register operand.

---
 rtl/dlx_fetch_unit.sv | 130 +++++++++++++
 tb/tb_dlx_fetch_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dlx_fetch_unit.sv
// dlx_fetch_unit: instruction-fetch stage of the single-issue DLX datapath.
// Owns the PC, fetches one word per instruction over an imem req/ack
// handshake, holds it for decode, and commits the next PC on retirement.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   imem_req_o/addr_o     fetch request and word address (= pc_o)
//   imem_ack_i/rdata_i    fetch response
//   inst_o, inst_valid_o  held instruction and its valid flag
//   pc_o, pc_plus4_o      address of inst_o and its link value
//   adv_i                 datapath retired inst_o; commit next PC
//   branch_z_i, branch_nz_i, jmp_i, jmp_r_i  decoder outputs for inst_o
//   bus_a_i               rs1 value: branch operand and register-jump target
//   retired_o             instructions retired since reset (wraps)
module dlx_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  input  logic        adv_i,
  input  logic        branch_z_i,
  input  logic        branch_nz_i,
  input  logic        jmp_i,
  input  logic        jmp_r_i,
  input  logic [31:0] bus_a_i,
  output logic [31:0] retired_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pc_plus4_q, pc_plus4_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   retired_q, retired_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;

  logic              br_taken;
  logic [XLEN-1:0]   jmp_off, br_off, next_pc;

  // Next-PC selection; only sampled when adv_i commits in HOLD.
  always_comb begin
    jmp_off  = {{6{inst_q[25]}}, inst_q[25:0]};
    br_off   = {{16{inst_q[15]}}, inst_q[15:0]};
    br_taken = (branch_z_i && (bus_a_i == '0)) || (branch_nz_i && (bus_a_i != '0));
    if (jmp_r_i) begin
      next_pc = {bus_a_i[31:2], 2'b00};
    end else if (jmp_i) begin
      next_pc = pc_plus4_q + jmp_off;
    end else if (br_taken) begin
      next_pc = pc_plus4_q + br_off;
    end else begin
      next_pc = pc_plus4_q;
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    inst_d     = inst_q;
    retired_d  = retired_q;
    unique case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (imem_ack_i) begin
          inst_d  = imem_rdata_i;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (adv_i) begin
          pc_d       = next_pc;
          pc_plus4_d = next_pc + XLEN'(4);
          retired_d  = retired_q + XLEN'(1);
          state_d    = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
    // Flags are registered from the next state so they track state_q exactly.
    req_d   = (state_d == FETCH);
    valid_d = (state_d == HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + XLEN'(4);
      inst_q     <= '0;
      retired_q  <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      inst_q     <= inst_d;
      retired_q  <= retired_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;
  assign pc_o         = pc_q;
  assign pc_plus4_o   = pc_plus4_q;
  assign retired_o    = retired_q;

endmodule

// File: tb/tb_dlx_fetch_unit.sv
// tb_dlx_fetch_unit: directed self-checking bench for dlx_fetch_unit.
module tb_dlx_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        adv;
  logic        branch_z, branch_nz, jmp, jmp_r;
  logic [31:0] bus_a;
  logic [31:0] retired;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dlx_fetch_unit #(.RESET_PC(32'h100)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (imem_ack),
    .imem_rdata_i (imem_rdata),
    .inst_o       (inst),
    .inst_valid_o (inst_valid),
    .pc_o         (pc),
    .pc_plus4_o   (pc_plus4),
    .adv_i        (adv),
    .branch_z_i   (branch_z),
    .branch_nz_i  (branch_nz),
    .jmp_i        (jmp),
    .jmp_r_i      (jmp_r),
    .bus_a_i      (bus_a),
    .retired_o    (retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one fetch at exp_addr, acking after 'delay' stalled cycles.
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int delay);
    int lat;
    lat = 0;
    check("fetch_req", 32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr, exp_addr);
    while (!inst_valid && lat < 20) begin
      imem_ack   = (lat == delay);
      imem_rdata = word;
      tick();
      lat++;
      if (!inst_valid) check("stall_addr", imem_addr, exp_addr);
    end
    imem_ack = 1'b0;
    check("ack_latency", 32'(lat), 32'(delay + 1));
    check("inst", inst, word);
  endtask

  // Retire the held instruction with the given decoder outputs.
  task automatic retire(input logic bz, input logic bnz, input logic j, input logic jr,
                        input logic [31:0] a, input logic [31:0] exp_pc);
    branch_z = bz; branch_nz = bnz; jmp = j; jmp_r = jr; bus_a = a;
    adv = 1'b1;
    tick();
    adv = 1'b0; branch_z = 0; branch_nz = 0; jmp = 0; jmp_r = 0; bus_a = '0;
    check("next_pc", pc, exp_pc);
    check("after_adv_req", 32'(imem_req), 32'd1);
    check("after_adv_valid", 32'(inst_valid), 32'd0);
  endtask

  // Redirect to target with a register jump so the next test starts there.
  task automatic goto_pc(input logic [31:0] cur, input logic [31:0] target);
    do_fetch(cur, 32'h0000_0000, 0);
    retire(0, 0, 0, 1, target, target);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_ack = 0; imem_rdata = '0; adv = 0;
    branch_z = 0; branch_nz = 0; jmp = 0; jmp_r = 0; bus_a = '0;
    tick(); tick();
    check("rst_pc", pc, 32'h100);
    check("rst_addr", imem_addr, 32'h100);
    check("rst_pc4", pc_plus4, 32'h104);
    check("rst_inst", inst, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_retired", retired, 32'h0);
    rst = 1'b0;
    check("boot_req", 32'(imem_req), 32'd0);
    tick();

    // Sequential fetches with 0, 1 and 3 stall cycles.
    do_fetch(32'h100, 32'hA000_0001, 0);
    tick();
    check("hold_valid", 32'(inst_valid), 32'd1);
    check("hold_req", 32'(imem_req), 32'd0);
    retire(0, 0, 0, 0, 32'h0, 32'h104);
    do_fetch(32'h104, 32'hA000_0002, 1);
    tick();
    retire(0, 0, 0, 0, 32'h0, 32'h108);
    do_fetch(32'h108, 32'hA000_0003, 3);
    tick();
    retire(0, 0, 0, 0, 32'h0, 32'h10C);
    check("retired_3", retired, 32'd3);

    // Branches at 0x200 with offset -8.
    goto_pc(32'h10C, 32'h200);
    do_fetch(32'h200, 32'h1000_FFF8, 0);
    check("br_pc4", pc_plus4, 32'h204);
    retire(1, 0, 0, 0, 32'h0, 32'h1FC);
    goto_pc(32'h1FC, 32'h200);
    do_fetch(32'h200, 32'h1400_FFF8, 0);
    retire(0, 1, 0, 0, 32'h0, 32'h204);
    goto_pc(32'h204, 32'h200);
    do_fetch(32'h200, 32'h1400_FFF8, 0);
    retire(0, 1, 0, 0, 32'h5, 32'h1FC);

    // JAL at 0x40, JR with unaligned operand, jmp_r priority over jmp.
    goto_pc(32'h1FC, 32'h40);
    do_fetch(32'h40, 32'h0C00_0100, 0);
    check("jal_pc4", pc_plus4, 32'h44);
    retire(0, 0, 1, 0, 32'h0, 32'h144);
    do_fetch(32'h144, 32'h4800_0000, 0);
    retire(0, 0, 0, 1, 32'h1003, 32'h1000);
    do_fetch(32'h1000, 32'h0C00_0100, 0);
    retire(0, 0, 1, 1, 32'h2000, 32'h2000);

    // PC wrap.
    goto_pc(32'h2000, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4, 32'h0);
    do_fetch(32'hFFFF_FFFC, 32'h0000_0020, 0);
    retire(0, 0, 0, 0, 32'h0, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    // Reset in HOLD with adv high.
    do_fetch(32'h0, 32'h1234_5678, 0);
    check("retired_15", retired, 32'd15);
    rst = 1'b1; adv = 1'b1;
    tick();
    rst = 1'b0; adv = 1'b0;
    check("rsthold_retired", retired, 32'h0);
    check("rsthold_pc", pc, 32'h100);
    check("rsthold_inst", inst, 32'h0);
    check("rsthold_valid", 32'(inst_valid), 32'd0);

    // Ack during BOOT is ignored.
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001;
    tick();
    imem_ack = 1'b0;
    check("bootack_valid", 32'(inst_valid), 32'd0);
    check("bootack_inst", inst, 32'h0);
    check("bootack_req", 32'(imem_req), 32'd1);

    // Reset in FETCH with simultaneous ack.
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0; imem_ack = 1'b0;
    check("rstfetch_inst", inst, 32'h0);
    check("rstfetch_req", 32'(imem_req), 32'd0);
    check("rstfetch_valid", 32'(inst_valid), 32'd0);
    tick();
    check("rstfetch_boot_exit", 32'(imem_req), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
